// File: rtl/im2col_addr_gen.sv
// im2col address generator: walks one output patch against one kernel over
// K = C*KH*KW flat elements, emitting PACK kernel/map addresses per beat.
module im2col_addr_gen #(
  parameter int PACK    = 4,
  parameter int CHUNK_K = 8,
  parameter int MAX_KH  = 7,
  parameter int MAX_KW  = 7,
  parameter int MAX_C   = 64,
  parameter int MAX_H   = 64,
  parameter int MAX_W   = 64,
  parameter int A_AW    = 16,
  parameter int B_AW    = 18
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [$clog2(MAX_C):0]        cfg_c,
  input  logic [$clog2(MAX_KH):0]       cfg_kh,
  input  logic [$clog2(MAX_KW):0]       cfg_kw,
  input  logic [$clog2(MAX_H):0]        cfg_h,
  input  logic [$clog2(MAX_W):0]        cfg_w,
  input  logic [2:0]                    cfg_stride,
  input  logic [2:0]                    cfg_pad,
  input  logic [$clog2(MAX_H):0]        patch_i,
  input  logic [$clog2(MAX_W):0]        patch_j,
  input  logic [15:0]                   kern_n,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [A_AW*PACK-1:0]          a_addr,
  output logic [B_AW*PACK-1:0]          b_addr,
  output logic [PACK-1:0]               lane_zero,
  output logic [15:0]                   k_grp,
  output logic [$clog2(CHUNK_K):0]      beat_idx,
  output logic                          grp_last,
  output logic                          busy,
  output logic                          done,
  output logic                          cfg_err,
  output logic [1:0]                    dbg_state
);
  localparam int CW  = $clog2(MAX_C) + 1;
  localparam int KHW = $clog2(MAX_KH) + 1;
  localparam int KWW = $clog2(MAX_KW) + 1;
  localparam int HW  = $clog2(MAX_H) + 1;
  localparam int WW  = $clog2(MAX_W) + 1;
  localparam int BIW = $clog2(CHUNK_K) + 1;
  localparam int SW  = B_AW + 2;
  localparam logic signed [SW-1:0] ONE = 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  // r, q and b track row0+u, col0+v and c*plane+r*W+q so no per-beat multiply is needed
  typedef struct packed {
    logic [15:0]           f;
    logic [CW-1:0]         c;
    logic [KHW-1:0]        u;
    logic [KWW-1:0]        v;
    logic signed [SW-1:0]  r;
    logic signed [SW-1:0]  q;
    logic signed [SW-1:0]  b;
  } lane_t;

  state_t state_q, state_d;
  logic [CW-1:0]  c_q;
  logic [KHW-1:0] kh_q;
  logic [KWW-1:0] kw_q;
  logic [HW-1:0]  h_q, pi_q;
  logic [WW-1:0]  w_q, pj_q;
  logic [2:0]     s_q, p_q;
  logic [15:0]    n_q, k_q, grp_q;
  logic [A_AW-1:0] base_a_q;
  logic signed [SW-1:0] row0_q, col0_q, step_row_q, step_ch_q;
  lane_t          base_q;
  logic [BIW-1:0] beat_q;
  logic           err_q;

  logic [15:0]    k_c;
  logic [31:0]    a_prod_c;
  logic signed [SW-1:0] row0_c, col0_c, plane_c, b0_c, step_row_c, step_ch_c;
  logic           cfg_bad, run, accept, last_beat;
  lane_t          ln [PACK+1];

  function automatic logic signed [SW-1:0] sx(input logic [15:0] x);
    return $signed({{(SW-16){1'b0}}, x});
  endfunction

  // Setup arithmetic; only registered while in LOAD
  always_comb begin
    k_c        = 16'(c_q) * 16'(kh_q) * 16'(kw_q);
    a_prod_c   = 32'(n_q) * 32'(k_c);
    row0_c     = sx(16'(pi_q)) * sx(16'(s_q)) - sx(16'(p_q));
    col0_c     = sx(16'(pj_q)) * sx(16'(s_q)) - sx(16'(p_q));
    plane_c    = sx(16'(h_q)) * sx(16'(w_q));
    b0_c       = row0_c * sx(16'(w_q)) + col0_c;
    step_row_c = sx(16'(w_q)) - sx(16'(kw_q)) + ONE;
    step_ch_c  = plane_c - (sx(16'(kh_q)) - ONE) * sx(16'(w_q)) - sx(16'(kw_q)) + ONE;
    cfg_bad    = (kh_q == '0) || (int'(kh_q) > MAX_KH) ||
                 (kw_q == '0) || (int'(kw_q) > MAX_KW) ||
                 (c_q == '0)  || (int'(c_q) > MAX_C)   || (s_q == 3'd0);
  end

  // Lane e is lane e-1 stepped by one flat index; ln[PACK] is next beat's lane 0
  always_comb begin
    ln[0] = base_q;
    for (int e = 1; e <= PACK; e++) begin
      ln[e]   = ln[e-1];
      ln[e].f = ln[e-1].f + 16'd1;
      if (ln[e-1].v == kw_q - KWW'(1)) begin
        ln[e].v = '0;
        ln[e].q = col0_q;
        if (ln[e-1].u == kh_q - KHW'(1)) begin
          ln[e].u = '0;
          ln[e].r = row0_q;
          ln[e].c = ln[e-1].c + CW'(1);
          ln[e].b = ln[e-1].b + step_ch_q;
        end else begin
          ln[e].u = ln[e-1].u + KHW'(1);
          ln[e].r = ln[e-1].r + ONE;
          ln[e].b = ln[e-1].b + step_row_q;
        end
      end else begin
        ln[e].v = ln[e-1].v + KWW'(1);
        ln[e].q = ln[e-1].q + ONE;
        ln[e].b = ln[e-1].b + ONE;
      end
    end
  end

  assign run       = (state_q == S_RUN);
  assign accept    = run && out_ready;
  assign last_beat = (beat_q == BIW'(CHUNK_K - 1)) &&
                     (({1'b0, base_q.f} + 17'(PACK)) >= {1'b0, k_q});

  always_comb begin
    for (int e = 0; e < PACK; e++) begin
      logic in_k, oob;
      in_k = ln[e].f < k_q;
      oob  = ln[e].r[SW-1] || ($signed(ln[e].r) >= sx(16'(h_q))) ||
             ln[e].q[SW-1] || ($signed(ln[e].q) >= sx(16'(w_q)));
      lane_zero[e]             = run && (!in_k || oob);
      a_addr[e*A_AW +: A_AW]   = (run && in_k) ? base_a_q + A_AW'(ln[e].f) : '0;
      b_addr[e*B_AW +: B_AW]   = (run && in_k && !oob) ? ln[e].b[B_AW-1:0] : '0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_LOAD;
      S_LOAD: state_d = cfg_bad ? S_DONE : S_RUN;
      S_RUN:  if (accept && last_beat) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign out_valid = run;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign cfg_err   = err_q;
  assign grp_last  = run && last_beat;
  assign k_grp     = run ? grp_q : '0;
  assign beat_idx  = run ? beat_q : '0;
  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      c_q <= '0; kh_q <= '0; kw_q <= '0; h_q <= '0; w_q <= '0;
      s_q <= '0; p_q <= '0; pi_q <= '0; pj_q <= '0; n_q <= '0;
      k_q <= '0; base_a_q <= '0; row0_q <= '0; col0_q <= '0;
      step_row_q <= '0; step_ch_q <= '0;
      base_q <= '0; beat_q <= '0; grp_q <= '0; err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && start) begin
        c_q <= cfg_c; kh_q <= cfg_kh; kw_q <= cfg_kw; h_q <= cfg_h; w_q <= cfg_w;
        s_q <= cfg_stride; p_q <= cfg_pad; pi_q <= patch_i; pj_q <= patch_j;
        n_q <= kern_n; err_q <= 1'b0;
      end
      if (state_q == S_LOAD) begin
        k_q        <= k_c;
        base_a_q   <= a_prod_c[A_AW-1:0];
        row0_q     <= row0_c;
        col0_q     <= col0_c;
        step_row_q <= step_row_c;
        step_ch_q  <= step_ch_c;
        base_q     <= '{f: '0, c: '0, u: '0, v: '0, r: row0_c, q: col0_c, b: b0_c};
        beat_q     <= '0;
        grp_q      <= '0;
        err_q      <= cfg_bad;
      end
      if (accept) begin
        base_q <= ln[PACK];
        if (beat_q == BIW'(CHUNK_K - 1)) begin
          beat_q <= '0;
          grp_q  <= grp_q + 16'd1;
        end else begin
          beat_q <= beat_q + BIW'(1);
        end
      end
    end
  end
endmodule
